// File: rtl/id_counter_dco.sv
// id_counter_dco: increment/decrement DCO for the PLL feedback path.
// Applies loop-filter carry/borrow to a half-rate pulse train, divides to a square wave.
//
// Ports:
//   clk_i      system clock, rising edge
//   reset_i    asynchronous active-high reset
//   carry_i    advance request (loop filter max trigger)
//   borrow_i   retard request (loop filter min trigger)
//   idPulse_o  corrected pulse train, nominal clk/2
//   divClk_o   idPulse_o divided by DIVIDE, 50% duty in pulse units
//   advanced_o strobe: advance applied at previous edge
//   retarded_o strobe: retard applied at previous edge
module id_counter_dco #(
  parameter int DIVIDE    = 8,
  parameter int CNT_WIDTH = $clog2(DIVIDE)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic carry_i,
  input  logic borrow_i,
  output logic idPulse_o,
  output logic divClk_o,
  output logic advanced_o,
  output logic retarded_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DIVIDE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(DIVIDE / 2);

  logic                 t_q, t_d;
  logic                 pend_c_q, pend_c_d;
  logic                 pend_b_q, pend_b_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 adv_q, adv_d;
  logic                 ret_q, ret_d;

  logic c_req;
  logic b_req;

  assign c_req = pend_c_q | carry_i;
  assign b_req = pend_b_q | borrow_i;

  // Pulse-train correction; order of the branches is the priority.
  always_comb begin
    t_d      = ~t_q;
    pend_c_d = pend_c_q;
    pend_b_d = pend_b_q;
    adv_d    = 1'b0;
    ret_d    = 1'b0;
    if (c_req && b_req) begin
      // Opposite requests cancel; the train runs on undisturbed.
      pend_c_d = 1'b0;
      pend_b_d = 1'b0;
    end else if (c_req && t_q) begin
      // Hold high one extra cycle: period shortens to 1 cycle.
      t_d      = 1'b1;
      pend_c_d = 1'b0;
      adv_d    = 1'b1;
    end else if (b_req && !t_q) begin
      // Hold low one extra cycle: period lengthens to 3 cycles.
      t_d      = 1'b0;
      pend_b_d = 1'b0;
      ret_d    = 1'b1;
    end else begin
      // Wrong phase: park the request for the next edge.
      pend_c_d = c_req;
      pend_b_d = b_req;
    end
  end

  // Divider counts pulses using the pre-edge pulse level.
  always_comb begin
    cnt_d = cnt_q;
    if (t_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_WIDTH'(1);
    end
    div_d = (cnt_d >= CNT_HALF);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      t_q      <= 1'b0;
      pend_c_q <= 1'b0;
      pend_b_q <= 1'b0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      adv_q    <= 1'b0;
      ret_q    <= 1'b0;
    end else begin
      t_q      <= t_d;
      pend_c_q <= pend_c_d;
      pend_b_q <= pend_b_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      adv_q    <= adv_d;
      ret_q    <= ret_d;
    end
  end

  assign idPulse_o  = t_q;
  assign divClk_o   = div_q;
  assign advanced_o = adv_q;
  assign retarded_o = ret_q;

endmodule

// File: tb/tb_id_counter_dco.sv
// tb_id_counter_dco: directed self-checking bench for id_counter_dco.
// DIVIDE=4; outputs sampled 1ns after each rising edge.
module tb_id_counter_dco;

  logic clk_i = 1'b0;
  logic reset_i;
  logic carry_i;
  logic borrow_i;
  logic idPulse_o;
  logic divClk_o;
  logic advanced_o;
  logic retarded_o;

  int checks = 0;
  int errors = 0;

  id_counter_dco #(.DIVIDE(4)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .carry_i    (carry_i),
    .borrow_i   (borrow_i),
    .idPulse_o  (idPulse_o),
    .divClk_o   (divClk_o),
    .advanced_o (advanced_o),
    .retarded_o (retarded_o)
  );

  always #5 clk_i = ~clk_i;

  // {idPulse, divClk, advanced, retarded}
  function automatic logic [3:0] obs();
    return {idPulse_o, divClk_o, advanced_o, retarded_o};
  endfunction

  // Undisturbed output n edges after reset release.
  function automatic logic [3:0] nom(int n);
    logic id;
    logic dv;
    id = ((n % 2) == 1);
    dv = (((n / 2) % 4) >= 2);
    return {id, dv, 2'b00};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i  = 1'b1;
    carry_i  = 1'b0;
    borrow_i = 1'b0;
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    reset_i  = 1'b1;
    carry_i  = 1'b0;
    borrow_i = 1'b0;
    #1;
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async got %b exp 0000", obs());
    end
    step();
    step();
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held got %b exp 0000", obs());
    end
    reset_i = 1'b0;
    step();
    exp = 4'b1000;
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL reset_first_edge got %b exp %b", obs(), exp);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      step();
      checks++;
      if (obs() !== nom(n)) begin
        errors++;
        $display("FAIL nominal e%0d got %b exp %b", n, obs(), nom(n));
      end
    end
  endtask

  task automatic test_carry_t1();
    logic [3:0] exp [0:7];
    exp = '{4'b1010, 4'b0100, 4'b1100, 4'b0100,
            4'b1100, 4'b0000, 4'b1000, 4'b0000};
    do_reset();
    step();
    carry_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      carry_i = 1'b0;
      checks++;
      if (obs() !== exp[i]) begin
        errors++;
        $display("FAIL carry_t1 e%0d got %b exp %b", i + 2, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_carry_t0();
    logic [3:0] exp [0:7];
    exp = '{4'b1000, 4'b1110, 4'b0100, 4'b1100,
            4'b0000, 4'b1000, 4'b0000, 4'b1000};
    do_reset();
    step();
    step();
    carry_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      carry_i = 1'b0;
      checks++;
      if (obs() !== exp[i]) begin
        errors++;
        $display("FAIL carry_t0 e%0d got %b exp %b", i + 3, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_borrow_t0();
    logic [3:0] exp [0:7];
    exp = '{4'b0001, 4'b1000, 4'b0100, 4'b1100,
            4'b0100, 4'b1100, 4'b0000, 4'b1000};
    do_reset();
    step();
    step();
    borrow_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      borrow_i = 1'b0;
      checks++;
      if (obs() !== exp[i]) begin
        errors++;
        $display("FAIL borrow_t0 e%0d got %b exp %b", i + 3, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_cancel_same();
    do_reset();
    step();
    carry_i  = 1'b1;
    borrow_i = 1'b1;
    for (int n = 2; n <= 9; n++) begin
      step();
      carry_i  = 1'b0;
      borrow_i = 1'b0;
      checks++;
      if (obs() !== nom(n)) begin
        errors++;
        $display("FAIL cancel_same e%0d got %b exp %b", n, obs(), nom(n));
      end
    end
  endtask

  task automatic test_cancel_split();
    do_reset();
    step();
    step();
    carry_i = 1'b1;
    for (int n = 3; n <= 10; n++) begin
      step();
      carry_i  = 1'b0;
      borrow_i = (n == 3);
      checks++;
      if (obs() !== nom(n)) begin
        errors++;
        $display("FAIL cancel_split e%0d got %b exp %b", n, obs(), nom(n));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    step();
    step();
    borrow_i = 1'b1;
    step();
    borrow_i = 1'b0;
    checks++;
    if (obs() !== 4'b0100) begin
      errors++;
      $display("FAIL mid_setup got %b exp 0100", obs());
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async got %b exp 0000", obs());
    end
    step();
    step();
    reset_i = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      checks++;
      if (obs() !== nom(n)) begin
        errors++;
        $display("FAIL mid_restart e%0d got %b exp %b", n, obs(), nom(n));
      end
    end
  endtask

  initial begin
    reset_i  = 1'b1;
    carry_i  = 1'b0;
    borrow_i = 1'b0;
    test_reset();
    test_nominal();
    test_carry_t1();
    test_carry_t0();
    test_borrow_t0();
    test_cancel_same();
    test_cancel_split();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
